// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg -- shared widths, named registers and helpers for the regfile
// writeback arbiter.            Rev 1.0
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NREGS      = 32;

    localparam logic [REG_ADDR_W-1:0] R31 = 5'd31;
    localparam logic [REG_ADDR_W-1:0] XP  = 5'd30;
    localparam logic [REG_ADDR_W-1:0] SP  = 5'd29;
    localparam logic [REG_ADDR_W-1:0] LP  = 5'd28;
    localparam logic [REG_ADDR_W-1:0] BP  = 5'd27;

    typedef enum logic [0:0] {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_src_e;

    function automatic logic [5:0] popcount32(input logic [NREGS-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter_if -- issue, ALU/MEM writeback, regfile write port and
// status signals of the writeback arbiter.        Rev 1.0
// ============================================================================
interface regfile_wb_arbiter_if import regfile_pkg::*; ();

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic [REG_ADDR_W-1:0] issue_src_a;
    logic [REG_ADDR_W-1:0] issue_src_b;
    logic                  issue_stall;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0]     alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_ready;

    logic                  werf;
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wdata;

    logic [5:0]            pending_count;
    logic                  err_unexpected;

    modport slave (
        input  issue_valid, issue_dest, issue_src_a, issue_src_b,
        output issue_stall,
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output werf, wa, wdata,
        output pending_count, err_unexpected
    );

    modport master (
        output issue_valid, issue_dest, issue_src_a, issue_src_b,
        input  issue_stall,
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  werf, wa, wdata,
        input  pending_count, err_unexpected
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 -- two-way round-robin arbiter with one-hot grant; bit 0 = ALU,
// bit 1 = MEM.                    Rev 1.0
// ============================================================================
module rr_arb2 import regfile_pkg::*; #(
    parameter bit ALU_FIRST = 1'b1
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o
);

    grant_src_e last_q;
    grant_src_e last_d;

    // Seeding "last" with the other requester gives the preferred one the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= ALU_FIRST ? GRANT_MEM : GRANT_ALU;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == GRANT_MEM) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = GRANT_ALU;
        end else if (gnt_o[1]) begin
            last_d = GRANT_MEM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter -- pending-write scoreboard with issue hazard stall and
// round-robin ALU/MEM writeback onto a single regfile write port.  Rev 1.0
// ============================================================================
module regfile_wb_arbiter import regfile_pkg::*; #(
    parameter int unsigned ZERO_REG  = 31,
    parameter bit          ALU_FIRST = 1'b1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    regfile_wb_arbiter_if.slave   bus
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [NREGS-1:0]      pending_q, pending_d;
    logic [5:0]            count_q;
    logic                  err_q, err_d;
    logic                  werf_q, werf_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic                  hz_a, hz_b, hz_d, stall;
    logic [1:0]            req, gnt;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0]     xfer_data;

    assign hz_a  = (bus.issue_src_a != ZERO_ADDR) && pending_q[bus.issue_src_a];
    assign hz_b  = (bus.issue_src_b != ZERO_ADDR) && pending_q[bus.issue_src_b];
    assign hz_d  = (bus.issue_dest  != ZERO_ADDR) && pending_q[bus.issue_dest];
    assign stall = !reset && bus.issue_valid && (hz_a || hz_b || hz_d);

    // Requests are masked during reset so no grant can be seen while state is cleared.
    assign req = {bus.mem_valid, bus.alu_valid} & {2{!reset}};

    rr_arb2 #(
        .ALU_FIRST (ALU_FIRST)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign xfer      = |gnt;
    assign xfer_addr = gnt[1] ? bus.mem_addr : bus.alu_addr;
    assign xfer_data = gnt[1] ? bus.mem_data : bus.alu_data;

    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        werf_d    = 1'b0;
        wa_d      = wa_q;
        wdata_d   = wdata_q;
        if (xfer && (xfer_addr != ZERO_ADDR)) begin
            werf_d              = 1'b1;
            wa_d                = xfer_addr;
            wdata_d             = xfer_data;
            err_d               = err_q || !pending_q[xfer_addr];
            pending_d[xfer_addr] = 1'b0;
        end
        // Same-register set/clear cannot coincide: that issue would have stalled.
        if (bus.issue_valid && !stall && (bus.issue_dest != ZERO_ADDR)) begin
            pending_d[bus.issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            werf_q    <= 1'b0;
            wa_q      <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= popcount32(pending_d);
            err_q     <= err_d;
            werf_q    <= werf_d;
            wa_q      <= wa_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.issue_stall    = stall;
    assign bus.alu_ready      = gnt[0];
    assign bus.mem_ready      = gnt[1];
    assign bus.werf           = werf_q;
    assign bus.wa             = wa_q;
    assign bus.wdata          = wdata_q;
    assign bus.pending_count  = count_q;
    assign bus.err_unexpected = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter -- directed scenarios plus randomized traffic checked
// against a scoreboard model of the pending set and writeback arbitration.
// Rev 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam bit ALU_FIRST = 1'b1;
    localparam logic [4:0] ZR = 5'd31;

    logic clock;
    logic reset;

    regfile_wb_arbiter_if bif ();

    regfile_wb_arbiter #(
        .ZERO_REG  (31),
        .ALU_FIRST (ALU_FIRST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Scoreboard state
    bit [31:0] m_pend;
    bit        m_alu_turn;
    bit        m_err;
    bit        m_werf;
    bit [4:0]  m_wa;
    bit [31:0] m_wdata;
    bit        m_chk_wa;
    bit        e_ga, e_gm, e_stall;
    logic      o_ga, o_gm, o_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bif.issue_valid = 1'b0; bif.issue_dest = '0; bif.issue_src_a = '0; bif.issue_src_b = '0;
        bif.alu_valid = 1'b0; bif.alu_addr = '0; bif.alu_data = '0;
        bif.mem_valid = 1'b0; bif.mem_addr = '0; bif.mem_data = '0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_alu_turn = ALU_FIRST; m_err = 0;
        m_werf = 0; m_wa = '0; m_wdata = '0; e_ga = 0; e_gm = 0;
    endtask

    // Called at posedge+1 with reset low and inputs driven; returns at next posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        #1;
        model_reset();
        check("rst_cnt",   bif.pending_count, 0);
        check("rst_werf",  bif.werf, 0);
        check("rst_wa",    bif.wa, 0);
        check("rst_wdata", bif.wdata, 0);
        check("rst_err",   bif.err_unexpected, 0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic step();
        bit        xfer;
        bit [4:0]  a;
        bit [31:0] d;
        #1;
        e_stall = bif.issue_valid &&
                  ((bif.issue_src_a != ZR && m_pend[bif.issue_src_a]) ||
                   (bif.issue_src_b != ZR && m_pend[bif.issue_src_b]) ||
                   (bif.issue_dest  != ZR && m_pend[bif.issue_dest]));
        if (bif.alu_valid && bif.mem_valid) begin
            e_ga = m_alu_turn; e_gm = !m_alu_turn;
        end else begin
            e_ga = bif.alu_valid; e_gm = bif.mem_valid;
        end
        o_ga = bif.alu_ready; o_gm = bif.mem_ready; o_stall = bif.issue_stall;
        check("stall",     o_stall, e_stall);
        check("alu_ready", o_ga, e_ga);
        check("mem_ready", o_gm, e_gm);

        xfer = e_ga || e_gm;
        a    = e_gm ? bif.mem_addr : bif.alu_addr;
        d    = e_gm ? bif.mem_data : bif.alu_data;
        m_werf   = 0;
        m_chk_wa = !xfer;
        if (xfer && a != ZR) begin
            if (!m_pend[a]) m_err = 1;
            m_pend[a] = 0;
            m_werf = 1; m_wa = a; m_wdata = d; m_chk_wa = 1;
        end
        if (bif.issue_valid && !e_stall && bif.issue_dest != ZR)
            m_pend[bif.issue_dest] = 1;
        if (e_ga) m_alu_turn = 0;
        if (e_gm) m_alu_turn = 1;

        @(posedge clock); #1;
        check("werf",  bif.werf, m_werf);
        if (m_chk_wa) begin
            check("wa",    bif.wa, m_wa);
            check("wdata", bif.wdata, m_wdata);
        end
        check("pending_count", bif.pending_count, $countones(m_pend));
        check("err",   bif.err_unexpected, m_err);
    endtask

    initial begin
        int cnt_before;
        reset = 1'b1;
        drive_idle();
        model_reset();
        @(posedge clock); #1;
        do_reset();

        // Issue dest=5 then a dependent issue on src_a=5
        bif.issue_valid = 1; bif.issue_dest = 5'd5; bif.issue_src_a = 5'd1; bif.issue_src_b = 5'd2;
        step();
        check("s1_cnt", bif.pending_count, 1);
        bif.issue_dest = 5'd6; bif.issue_src_a = 5'd5;
        step();
        check("s1_stall", o_stall, 1);

        // ALU writeback of reg 5 releases the hazard
        bif.issue_valid = 0;
        bif.alu_valid = 1; bif.alu_addr = 5'd5; bif.alu_data = 32'hDEADBEEF;
        step();
        check("s2_ready", o_ga, 1);
        check("s2_werf",  bif.werf, 1);
        check("s2_wa",    bif.wa, 5);
        check("s2_wdata", bif.wdata, 32'hDEADBEEF);
        check("s2_cnt",   bif.pending_count, 0);
        bif.alu_valid = 0;
        bif.issue_valid = 1; bif.issue_dest = 5'd6; bif.issue_src_a = 5'd5;
        step();
        check("s2_nostall", o_stall, 0);

        // Both requesters contend for four cycles
        do_reset();
        bif.alu_valid = 1; bif.alu_addr = 5'd10; bif.alu_data = 32'hA000_0000;
        bif.mem_valid = 1; bif.mem_addr = 5'd20; bif.mem_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_alu",  o_ga, (i % 2 == 0) ? 1 : 0);
            check("rr_mem",  o_gm, (i % 2 == 1) ? 1 : 0);
            check("rr_werf", bif.werf, 1);
            if (e_ga) begin bif.alu_addr++; bif.alu_data++; end
            if (e_gm) begin bif.mem_addr++; bif.mem_data++; end
        end
        bif.alu_valid = 0; bif.mem_valid = 0;

        // Writeback and issue to the hard-zero register
        bif.mem_valid = 1; bif.mem_addr = ZR; bif.mem_data = 32'h1234_5678;
        step();
        check("s4_ready", o_gm, 1);
        check("s4_werf",  bif.werf, 0);
        bif.mem_valid = 0;
        cnt_before = $countones(m_pend);
        bif.issue_valid = 1; bif.issue_dest = ZR; bif.issue_src_a = ZR; bif.issue_src_b = ZR;
        step();
        check("s4_stall", o_stall, 0);
        check("s4_cnt",   bif.pending_count, cnt_before);
        bif.issue_valid = 0;

        // Unexpected writeback is sticky
        do_reset();
        bif.alu_valid = 1; bif.alu_addr = 5'd7; bif.alu_data = 32'h0000_0077;
        step();
        check("s5_werf", bif.werf, 1);
        check("s5_wa",   bif.wa, 7);
        check("s5_err",  bif.err_unexpected, 1);
        bif.alu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s5_sticky", bif.err_unexpected, 1);
        end

        // Reset in the middle of a granted transfer with three pending
        bif.issue_valid = 1; bif.issue_src_a = 5'd0; bif.issue_src_b = 5'd0;
        for (int i = 1; i <= 3; i++) begin
            bif.issue_dest = 5'(i);
            step();
        end
        check("s6_cnt3", bif.pending_count, 3);
        bif.issue_valid = 0;
        bif.alu_valid = 1; bif.alu_addr = 5'd1; bif.alu_data = 32'hCAFE_F00D;
        #1;
        check("s6_grant", bif.alu_ready, 1);
        #2;
        reset = 1'b1;
        bif.issue_valid = 1; bif.mem_valid = 1;
        #1;
        model_reset();
        check("s6_cnt",   bif.pending_count, 0);
        check("s6_werf",  bif.werf, 0);
        check("s6_err",   bif.err_unexpected, 0);
        check("s6_aready", bif.alu_ready, 0);
        check("s6_mready", bif.mem_ready, 0);
        check("s6_stall", bif.issue_stall, 0);
        @(posedge clock); #1;
        check("s6_werf_post", bif.werf, 0);
        reset = 1'b0;
        drive_idle();

        // Randomized traffic; a requester holds its payload until granted
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int r;
            if (!(bif.alu_valid && !e_ga)) begin
                r = $urandom_range(0, 8);
                bif.alu_valid = ($urandom_range(0, 1) == 1);
                bif.alu_addr  = (r == 8) ? ZR : 5'(r);
                bif.alu_data  = $urandom;
            end
            if (!(bif.mem_valid && !e_gm)) begin
                r = $urandom_range(0, 8);
                bif.mem_valid = ($urandom_range(0, 1) == 1);
                bif.mem_addr  = (r == 8) ? ZR : 5'(r);
                bif.mem_data  = $urandom;
            end
            bif.issue_valid = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 8); bif.issue_dest  = (r == 8) ? ZR : 5'(r);
            r = $urandom_range(0, 8); bif.issue_src_a = (r == 8) ? ZR : 5'(r);
            r = $urandom_range(0, 8); bif.issue_src_b = (r == 8) ? ZR : 5'(r);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL take parameter ZERO_REG, default 31: register that always reads 0; writes to it are discarded.
REQ-002 The block SHALL take parameter ALU_FIRST, default 1: round-robin priority after reset (1 = ALU, 0 = MEM).
REQ-003 The block SHALL use one clock and an asynchronous active-high reset: `clock  in  1  rising-edge clock`; `reset  in  1  asynchronous, active-high`.
REQ-004 The block SHALL have these issue ports:
  - `issue_valid  in  1  instruction issue attempt`
  - `issue_dest  in  5  destination register`
  - `issue_src_a  in  5  source A`
  - `issue_src_b  in  5  source B`
  - `issue_stall  out  1  issue blocked by hazard`
REQ-005 The block SHALL have these ALU writeback ports:
  - `alu_valid  in  1`
  - `alu_addr  in  5`
  - `alu_data  in  32`
  - `alu_ready  out  1  grant`
REQ-006 The block SHALL have these MEM writeback ports:
  - `mem_valid  in  1`
  - `mem_addr  in  5`
  - `mem_data  in  32`
  - `mem_ready  out  1  grant`
REQ-007 The block SHALL have these regfile write-port ports:
  - `werf  out  1  write enable`
  - `wa  out  5  write address`
  - `wdata  out  32  write data`
REQ-008 The block SHALL have these status ports:
  - `pending_count  out  6  outstanding scored writes`
  - `err_unexpected  out  1  sticky: writeback to non-pending register`

Function
REQ-009 A 32-bit pending vector SHALL track scored writes; bit ZERO_REG SHALL never be set.
REQ-010 issue_stall SHALL be combinational: issue_valid AND (pending[src_a] OR pending[src_b] OR pending[dest]), ignoring any operand equal to ZERO_REG.
REQ-011 An issue is accepted when issue_valid=1 and issue_stall=0; if dest != ZERO_REG, pending[dest] SHALL be set at the next rising edge.
REQ-012 alu_ready/mem_ready SHALL be combinational grants; at most one SHALL be 1 per cycle; a grant requires the matching valid=1.
REQ-013 If only one requester is valid, it SHALL be granted.
REQ-014 If both are valid, the requester not granted last SHALL win (round-robin); the last-grant register SHALL update only on a grant.
REQ-015 A transfer completes on a cycle with valid=1 and ready=1; a requester SHALL hold addr/data stable while valid=1 and ready=0.
REQ-016 On transfer, werf/wa/wdata SHALL be registered: asserted for exactly one cycle, the cycle after the grant (latency 1).
REQ-017 A transfer with addr=ZERO_REG SHALL complete (ready=1) but drive werf=0.
REQ-018 A transfer SHALL clear pending[addr] at the same edge that registers werf.
REQ-019 A transfer to a non-pending, non-ZERO_REG address SHALL still write, and SHALL set err_unexpected until reset.
REQ-020 Same-edge issue-set and writeback-clear on one register cannot occur (the issue stalls per REQ-010); set and clear on different registers SHALL both take effect.
REQ-021 pending_count SHALL equal the popcount of pending, registered, with a range of 0..31.
REQ-022 When no transfer occurs, werf SHALL be 0; wa/wdata SHALL hold their previous values.

Reset
REQ-023 Reset SHALL asynchronously clear all state:
  - pending=0, pending_count=0, err_unexpected=0
  - werf=0, wa=0, wdata=0
  - last-grant set per ALU_FIRST
REQ-024 Reset mid-transfer SHALL drop the transfer (werf stays 0); requesters re-present after reset.
REQ-025 While reset=1, issue_stall, alu_ready and mem_ready SHALL be 0.

Structure
REQ-026 Package regfile_pkg SHALL hold: REG_ADDR_W=5, DATA_W=32, NREGS=32, and named register constants R31=31, XP=30, SP=29, LP=28, BP=27.
REQ-027 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2 requests in, one-hot grant out, last-grant state inside).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Issue dest=5 with no hazard → next cycle pending[5]=1, pending_count=1; issue src_a=5 → issue_stall=1.
  - ALU writes addr=5, data=0xDEADBEEF → alu_ready=1; next cycle werf=1, wa=5, wdata=0xDEADBEEF; pending[5]=0, stall released.
  - Both valid, ALU_FIRST=1, for 4 cycles → grants ALU, MEM, ALU, MEM; werf high 4 consecutive cycles.
  - MEM writes addr=31 → mem_ready=1, werf stays 0; issue dest=31 → no stall, pending_count unchanged.
  - Writeback to non-pending addr=7 → werf=1, wa=7; err_unexpected=1 and stays 1 until reset.
  - Reset asserted mid-grant with 3 pending → immediately pending_count=0, werf=0, err_unexpected=0.
